pc_gen_redirect: RTL and testbench

- Parametrised fetch-stage PC generator for the MIPS pipeline core.
- Drives the instruction-SRAM request address (`pc_f`) through a req/addr_ok handshake.
- Selects the next PC from exception, ERET, branch/jump redirect or sequential increment.
- Latches a branch redirect that arrives while fetch is stalled or the request is not accepted, then applies it on the next accepted request.

---
 rtl/pc_gen_redirect.sv | 80 ++++++++
 tb/tb_pc_gen_redirect.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_redirect.sv
// Fetch-stage PC generator: selects the next fetch address from exception, ERET,
// branch redirect or sequential increment, and latches branches that miss an accept.
module pc_gen_redirect #(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_VEC = ADDR_W'(32'hbfc00000),
  parameter logic [ADDR_W-1:0]   EXC_VEC   = ADDR_W'(32'hbfc00380),
  parameter int unsigned         INC       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              exc_valid,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] epc,
  input  logic              branch_taken_d,
  input  logic [ADDR_W-1:0] branch_target_d,
  input  logic              inst_addr_ok,
  output logic              inst_req,
  output logic [ADDR_W-1:0] pc_f,
  output logic              pc_adel_f,
  output logic              redirect_pending
);

  logic              started;
  logic              pending;
  logic [ADDR_W-1:0] pending_target;
  logic              accept;

  logic [ADDR_W-1:0] pc_next;
  logic              pending_next;
  logic [ADDR_W-1:0] pending_target_next;

  // No request goes out until the first edge after reset release
  assign pc_adel_f        = |pc_f[1:0];
  assign inst_req         = started & ~stall_f & ~pc_adel_f;
  assign accept           = inst_req & inst_addr_ok;
  assign redirect_pending = pending;

  // Next-PC selection; exception beats ERET beats everything else
  always_comb begin
    pc_next             = pc_f;
    pending_next        = pending;
    pending_target_next = pending_target;
    if (exc_valid) begin
      pc_next      = EXC_VEC;
      pending_next = 1'b0;
    end else if (eret_valid) begin
      pc_next      = epc;
      pending_next = 1'b0;
    end else if (accept) begin
      if (branch_taken_d) begin
        pc_next = branch_target_d;
      end else if (pending) begin
        pc_next = pending_target;
      end else begin
        pc_next = pc_f + ADDR_W'(INC);
      end
      pending_next = 1'b0;
    end else if (branch_taken_d) begin
      // A newer branch overwrites any older pending redirect
      pending_next        = 1'b1;
      pending_target_next = branch_target_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started        <= 1'b0;
      pc_f           <= RESET_VEC;
      pending        <= 1'b0;
      pending_target <= '0;
    end else begin
      started        <= 1'b1;
      pc_f           <= pc_next;
      pending        <= pending_next;
      pending_target <= pending_target_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_redirect.sv
// Directed bench for pc_gen_redirect: sequential fetch, stalled branches,
// exception/ERET priority, misaligned PC, wrap-around and async reset.
module tb_pc_gen_redirect;

  logic        clock;
  logic        reset;
  logic        stall_f;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        branch_taken_d;
  logic [31:0] branch_target_d;
  logic        inst_addr_ok;
  logic        inst_req;
  logic [31:0] pc_f;
  logic        pc_adel_f;
  logic        redirect_pending;

  int tests;
  int failed;

  pc_gen_redirect dut (
    .clock            (clock),
    .reset            (reset),
    .stall_f          (stall_f),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .branch_taken_d   (branch_taken_d),
    .branch_target_d  (branch_target_d),
    .inst_addr_ok     (inst_addr_ok),
    .inst_req         (inst_req),
    .pc_f             (pc_f),
    .pc_adel_f        (pc_adel_f),
    .redirect_pending (redirect_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_f = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
    epc = '0; branch_taken_d = 1'b0; branch_target_d = '0; inst_addr_ok = 1'b1;
    tick(); tick();
    tests++;
    if (pc_f !== 32'hbfc00000) begin failed++; $display("FAIL reset_pc got=%h exp=bfc00000", pc_f); end
    tests++;
    if (inst_req !== 1'b0 || redirect_pending !== 1'b0 || pc_adel_f !== 1'b0) begin
      failed++; $display("FAIL reset_flags got req=%b pend=%b adel=%b exp=0 0 0", inst_req, redirect_pending, pc_adel_f);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (inst_req !== 1'b0) begin failed++; $display("FAIL req_before_first_edge got=%b exp=0", inst_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [0:5];
    exp_pc[0] = 32'hbfc00000; exp_pc[1] = 32'hbfc00004; exp_pc[2] = 32'hbfc00008;
    exp_pc[3] = 32'hbfc0000c; exp_pc[4] = 32'hbfc00010; exp_pc[5] = 32'hbfc00010;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (pc_f !== exp_pc[i] || inst_req !== 1'b1) begin
        failed++; $display("FAIL seq_step%0d got pc=%h req=%b exp pc=%h req=1", i, pc_f, inst_req, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall_branch();
    stall_f = 1'b1; branch_taken_d = 1'b1; branch_target_d = 32'hbfc00100;
    #1;
    tests++;
    if (inst_req !== 1'b0) begin failed++; $display("FAIL stall_req got=%b exp=0", inst_req); end
    tick();
    branch_taken_d = 1'b0; branch_target_d = '0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (pc_f !== 32'hbfc00010 || redirect_pending !== 1'b1) begin
        failed++; $display("FAIL stall_hold%0d got pc=%h pend=%b exp pc=bfc00010 pend=1", i, pc_f, redirect_pending);
      end
      tick();
    end
    stall_f = 1'b0;
    tick();
    tests++;
    if (pc_f !== 32'hbfc00100 || redirect_pending !== 1'b0) begin
      failed++; $display("FAIL pending_apply got pc=%h pend=%b exp pc=bfc00100 pend=0", pc_f, redirect_pending);
    end
  endtask

  task automatic test_exc_clears_pending();
    inst_addr_ok = 1'b0; branch_taken_d = 1'b1; branch_target_d = 32'hbfc00200;
    tick();
    branch_taken_d = 1'b0;
    tests++;
    if (pc_f !== 32'hbfc00100 || redirect_pending !== 1'b1) begin
      failed++; $display("FAIL noack_latch got pc=%h pend=%b exp pc=bfc00100 pend=1", pc_f, redirect_pending);
    end
    exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    tests++;
    if (pc_f !== 32'hbfc00380 || redirect_pending !== 1'b0) begin
      failed++; $display("FAIL exc_clear got pc=%h pend=%b exp pc=bfc00380 pend=0", pc_f, redirect_pending);
    end
    // Pending was dropped, so the next accepted fetch is sequential
    inst_addr_ok = 1'b1;
    tick();
    tests++;
    if (pc_f !== 32'hbfc00384) begin failed++; $display("FAIL post_exc_seq got=%h exp=bfc00384", pc_f); end
  endtask

  task automatic test_exc_eret();
    exc_valid = 1'b1; eret_valid = 1'b1; epc = 32'h80001000;
    tick();
    tests++;
    if (pc_f !== 32'hbfc00380) begin failed++; $display("FAIL exc_over_eret got=%h exp=bfc00380", pc_f); end
    exc_valid = 1'b0;
    tick();
    eret_valid = 1'b0;
    tests++;
    if (pc_f !== 32'h80001000) begin failed++; $display("FAIL eret got=%h exp=80001000", pc_f); end
  endtask

  task automatic test_misaligned();
    branch_taken_d = 1'b1; branch_target_d = 32'h80000002;
    tick();
    branch_taken_d = 1'b0;
    tests++;
    if (pc_f !== 32'h80000002 || pc_adel_f !== 1'b1 || inst_req !== 1'b0) begin
      failed++; $display("FAIL adel_enter got pc=%h adel=%b req=%b exp pc=80000002 adel=1 req=0", pc_f, pc_adel_f, inst_req);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (pc_f !== 32'h80000002 || inst_req !== 1'b0) begin
        failed++; $display("FAIL adel_hold%0d got pc=%h req=%b exp pc=80000002 req=0", i, pc_f, inst_req);
      end
    end
    branch_taken_d = 1'b1; branch_target_d = 32'hbfc00500;
    tick();
    branch_taken_d = 1'b0;
    tests++;
    if (pc_f !== 32'h80000002 || redirect_pending !== 1'b1) begin
      failed++; $display("FAIL adel_branch got pc=%h pend=%b exp pc=80000002 pend=1", pc_f, redirect_pending);
    end
    exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    tests++;
    if (pc_f !== 32'hbfc00380 || pc_adel_f !== 1'b0 || redirect_pending !== 1'b0) begin
      failed++; $display("FAIL adel_exit got pc=%h adel=%b pend=%b exp pc=bfc00380 adel=0 pend=0", pc_f, pc_adel_f, redirect_pending);
    end
  endtask

  task automatic test_wrap_and_reset();
    branch_taken_d = 1'b1; branch_target_d = 32'hfffffffc;
    tick();
    branch_taken_d = 1'b0;
    tests++;
    if (pc_f !== 32'hfffffffc) begin failed++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc_f); end
    tick();
    tests++;
    if (pc_f !== 32'h00000000) begin failed++; $display("FAIL wrap got=%h exp=00000000", pc_f); end
    tick();
    tests++;
    if (pc_f !== 32'h00000004) begin failed++; $display("FAIL after_wrap got=%h exp=00000004", pc_f); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (pc_f !== 32'hbfc00000 || inst_req !== 1'b0) begin
      failed++; $display("FAIL async_reset got pc=%h req=%b exp pc=bfc00000 req=0", pc_f, inst_req);
    end
    tick();
    reset = 1'b1;
    tick();
    tests++;
    if (pc_f !== 32'hbfc00000 || inst_req !== 1'b1) begin
      failed++; $display("FAIL rerelease got pc=%h req=%b exp pc=bfc00000 req=1", pc_f, inst_req);
    end
    tick();
    tests++;
    if (pc_f !== 32'hbfc00004) begin failed++; $display("FAIL rerelease_seq got=%h exp=bfc00004", pc_f); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_sequential();
    test_stall_branch();
    test_exc_clears_pending();
    test_exc_eret();
    test_misaligned();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
